// File: rtl/run_mon_pkg.sv
// run_mon_pkg: shared types and constants for the end-of-run monitor.
//   cause_e  - halt cause encoding reported on run_monitor.cause
//   state_t  - monitor FSM state, with localparam state constants
//   *_DEF    - default console/exit MMIO addresses
package run_mon_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_EXCEPTION = 3'd1,
    CAUSE_RANGE     = 3'd2,
    CAUSE_EXIT      = 3'd3,
    CAUSE_TIMEOUT   = 3'd4
  } cause_e;

  localparam logic [31:0] PUTC_ADDR_DEF = 32'h8000001c;
  localparam logic [31:0] EXIT_ADDR_DEF = 32'h8000002c;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_DRAIN = 2'd1;
  localparam state_t ST_HALT  = 2'd2;

endpackage

// File: rtl/run_mon_range_chk.sv
// run_mon_range_chk: combinational legal-range check for one memory channel.
//   ready  in   address-valid strobe for this channel
//   addr   in   channel address
//   awidth in   log2 byte size of the legal range (0 disables the check)
//   viol   out  address strobed with bits at or above awidth set
module run_mon_range_chk
  import run_mon_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            ready,
  input  logic [XLEN-1:0] addr,
  input  logic [5:0]      awidth,
  output logic            viol
);

  // A shift of XLEN or more leaves zero, so oversized ranges never flag.
  always_comb begin
    viol = ready && (awidth != 6'd0) && ((addr >> awidth) != '0);
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: end-of-run monitor for the three-stage RISC-V core.
// Watches fetch PC stalls, the exception flag, NCH memory channels for
// out-of-range addresses and MMIO stores (console PUTC and EXIT), and
// raises a registered, first-wins halt request with cause and info.
//   clk, resetb      clock; synchronous active-high reset
//   pc, exception    fetch PC and core exception flag
//   ch_ready/ch_addr per-channel address strobe and address (ch i at [i*XLEN +: XLEN])
//   st_valid/addr/data  data-store port, decoded for PUTC and EXIT
//   putc_valid/char  one-cycle console byte strobe
//   halt_req, done   event latched / run finished (sticky until reset)
//   cause, cause_info, err_ch  first event's cause, info word, channel index
//   stall_cnt        current stall count (frozen once the run stops)
module run_monitor
  import run_mon_pkg::*;
#(
  parameter int                XLEN         = 32,
  parameter int                NCH          = 2,
  parameter logic [NCH*6-1:0]  CH_AWIDTH    = {6'd17, 6'd17},
  parameter int                TIMEOUT      = 100,
  parameter int                CNT_W        = 8,
  parameter int                DRAIN_CYCLES = 1,
  parameter logic [XLEN-1:0]   PUTC_ADDR    = PUTC_ADDR_DEF,
  parameter logic [XLEN-1:0]   EXIT_ADDR    = EXIT_ADDR_DEF
) (
  input  logic                                  clk,
  input  logic                                  resetb,
  input  logic [XLEN-1:0]                       pc,
  input  logic                                  exception,
  input  logic [NCH-1:0]                        ch_ready,
  input  logic [NCH*XLEN-1:0]                   ch_addr,
  input  logic                                  st_valid,
  input  logic [XLEN-1:0]                       st_addr,
  input  logic [XLEN-1:0]                       st_data,
  output logic                                  putc_valid,
  output logic [7:0]                            putc_char,
  output logic                                  halt_req,
  output logic                                  done,
  output logic [2:0]                            cause,
  output logic [XLEN-1:0]                       cause_info,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] err_ch,
  output logic [CNT_W-1:0]                      stall_cnt
);

  localparam int ERR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_t            state;
  logic [XLEN-1:0]   prev_pc;
  logic [DRN_W-1:0]  drain_cnt;

  logic [NCH-1:0]    viol;
  logic              rng_hit;
  logic [ERR_W-1:0]  rng_ch;
  logic [XLEN-1:0]   rng_addr;
  logic              exit_hit;
  logic              putc_hit;
  logic              tmo_hit;
  logic              ev_hit;
  cause_e            ev_cause;
  logic [XLEN-1:0]   ev_info;
  logic [ERR_W-1:0]  ev_ch;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chk
    run_mon_range_chk #(.XLEN(XLEN)) u_chk (
      .ready  (ch_ready[gi]),
      .addr   (ch_addr[gi*XLEN +: XLEN]),
      .awidth (CH_AWIDTH[gi*6 +: 6]),
      .viol   (viol[gi])
    );
  end

  // Scan from the top down so the lowest violating channel is left standing.
  always_comb begin
    rng_hit  = 1'b0;
    rng_ch   = '0;
    rng_addr = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (viol[i]) begin
        rng_hit  = 1'b1;
        rng_ch   = ERR_W'(i);
        rng_addr = ch_addr[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    exit_hit = st_valid && (st_addr == EXIT_ADDR);
    putc_hit = st_valid && (st_addr == PUTC_ADDR);
    tmo_hit  = (stall_cnt > CNT_W'(TIMEOUT));
  end

  // Same-cycle priority: exception > range > exit > timeout.
  always_comb begin
    ev_hit   = 1'b1;
    ev_cause = CAUSE_NONE;
    ev_info  = '0;
    ev_ch    = '0;
    if (exception) begin
      ev_cause = CAUSE_EXCEPTION;
      ev_info  = pc;
    end else if (rng_hit) begin
      ev_cause = CAUSE_RANGE;
      ev_info  = rng_addr;
      ev_ch    = rng_ch;
    end else if (exit_hit) begin
      ev_cause = CAUSE_EXIT;
      ev_info  = st_data;
    end else if (tmo_hit) begin
      ev_cause = CAUSE_TIMEOUT;
      ev_info  = pc;
    end else begin
      ev_hit   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      state      <= ST_RUN;
      prev_pc    <= '0;
      drain_cnt  <= '0;
      stall_cnt  <= '0;
      putc_valid <= 1'b0;
      putc_char  <= '0;
      halt_req   <= 1'b0;
      done       <= 1'b0;
      cause      <= CAUSE_NONE;
      cause_info <= '0;
      err_ch     <= '0;
    end else begin
      putc_valid <= putc_hit && (state != ST_HALT);
      if (putc_hit && (state != ST_HALT)) begin
        putc_char <= st_data[7:0];
      end

      case (state)
        ST_RUN: begin
          prev_pc <= pc;
          if (pc == prev_pc) begin
            if (stall_cnt != '1) begin
              stall_cnt <= stall_cnt + CNT_W'(1);
            end
          end else begin
            stall_cnt <= '0;
          end

          if (ev_hit) begin
            halt_req   <= 1'b1;
            cause      <= ev_cause;
            cause_info <= ev_info;
            err_ch     <= ev_ch;
            if (DRAIN_CYCLES == 0) begin
              state <= ST_HALT;
              done  <= 1'b1;
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= DRN_W'(DRAIN_CYCLES);
            end
          end
        end

        // The counter reaching zero on this edge is what ends the drain,
        // so done appears DRAIN_CYCLES cycles after halt_req.
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - DRN_W'(1);
          if (drain_cnt == DRN_W'(1)) begin
            state <= ST_HALT;
            done  <= 1'b1;
          end
        end

        ST_HALT: begin
        end

        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

  logic        clk = 1'b0;
  logic        resetb;
  logic [31:0] pc;
  logic        exception;
  logic [1:0]  ch_ready;
  logic [63:0] ch_addr;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        putc_valid;
  logic [7:0]  putc_char;
  logic        halt_req;
  logic        done;
  logic [2:0]  cause;
  logic [31:0] cause_info;
  logic [0:0]  err_ch;
  logic [7:0]  stall_cnt;

  logic        pc_run;
  logic [31:0] exp_pc;
  int          passed = 0;
  int          total  = 0;

  localparam logic [31:0] PUTC_A = 32'h8000001c;
  localparam logic [31:0] EXIT_A = 32'h8000002c;

  run_monitor dut (
    .clk        (clk),
    .resetb     (resetb),
    .pc         (pc),
    .exception  (exception),
    .ch_ready   (ch_ready),
    .ch_addr    (ch_addr),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .putc_valid (putc_valid),
    .putc_char  (putc_char),
    .halt_req   (halt_req),
    .done       (done),
    .cause      (cause),
    .cause_info (cause_info),
    .err_ch     (err_ch),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (pc_run) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    resetb    = 1'b1;
    st_valid  = 1'b0;
    exception = 1'b0;
    ch_ready  = 2'b00;
    tick();
    resetb    = 1'b0;
  endtask

  task automatic check_idle(input string p);
    chk({p, "_stall"},  stall_cnt,  0);
    chk({p, "_done"},   done,       0);
    chk({p, "_halt"},   halt_req,   0);
    chk({p, "_cause"},  cause,      0);
    chk({p, "_info"},   cause_info, 0);
    chk({p, "_errch"},  err_ch,     0);
    chk({p, "_putcv"},  putc_valid, 0);
    chk({p, "_putcc"},  putc_char,  0);
  endtask

  initial begin
    resetb = 1'b1; pc = 32'h100; pc_run = 1'b1; exception = 1'b0;
    ch_ready = 2'b00; ch_addr = '0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    tick();
    tick();
    check_idle("rst");
    resetb = 1'b0;

    // Free-running PC never stalls
    for (int i = 0; i < 500; i++) begin
      tick();
      chk("run_stall", stall_cnt, 0);
      chk("run_done",  done,      0);
    end

    // Console byte
    st_valid = 1'b1; st_addr = PUTC_A; st_data = 32'h41;
    tick();
    st_valid = 1'b0;
    chk("putc_v",    putc_valid, 1);
    chk("putc_c",    putc_char,  8'h41);
    chk("putc_halt", halt_req,   0);
    tick();
    chk("putc_v_off", putc_valid, 0);

    // Exit code 7
    st_valid = 1'b1; st_addr = EXIT_A; st_data = 32'd7;
    tick();
    st_valid = 1'b0;
    chk("exit_halt",  halt_req,   1);
    chk("exit_cause", cause,      3);
    chk("exit_info",  cause_info, 7);
    chk("exit_done0", done,       0);
    tick();
    chk("exit_done1", done,       1);

    // Later events after exit are ignored; PUTC suppressed in HALT
    exception = 1'b1; ch_ready = 2'b01; ch_addr = {32'h0, 32'h00020000};
    st_valid = 1'b1; st_addr = PUTC_A; st_data = 32'h42;
    tick();
    tick();
    chk("post_cause", cause,      3);
    chk("post_info",  cause_info, 7);
    chk("post_errch", err_ch,     0);
    chk("post_done",  done,       1);
    chk("post_halt",  halt_req,   1);
    chk("post_putcv", putc_valid, 0);
    exception = 1'b0; ch_ready = 2'b00; st_valid = 1'b0;

    // Timeout: hold pc at 0x40
    do_reset();
    check_idle("rst2");
    for (int i = 0; i < 10; i++) tick();
    pc = 32'h40; pc_run = 1'b0;
    tick();
    chk("tmo_first", stall_cnt, 0);
    for (int i = 0; i < 101; i++) tick();
    chk("tmo_cnt101", stall_cnt, 101);
    chk("tmo_nohalt", halt_req,  0);
    tick();
    chk("tmo_halt",  halt_req,   1);
    chk("tmo_cause", cause,      4);
    chk("tmo_info",  cause_info, 32'h40);
    chk("tmo_done0", done,       0);
    chk("tmo_cnt",   stall_cnt,  102);
    tick();
    chk("tmo_done1", done,       1);
    tick();
    chk("tmo_frozen", stall_cnt, 102);
    pc_run = 1'b1;

    // Range: in-range then out-of-range on channel 1
    do_reset();
    ch_addr = {32'h0001fffc, 32'h0001fffc}; ch_ready = 2'b11;
    tick();
    chk("rng_inrange", halt_req, 0);
    ch_addr = {32'h00020000, 32'h0}; ch_ready = 2'b10;
    tick();
    ch_ready = 2'b00;
    chk("rng_halt",  halt_req,   1);
    chk("rng_cause", cause,      2);
    chk("rng_errch", err_ch,     1);
    chk("rng_info",  cause_info, 32'h00020000);

    // Both channels bad: lowest wins
    do_reset();
    ch_addr = {32'h00020000, 32'h00030000}; ch_ready = 2'b11;
    tick();
    ch_ready = 2'b00;
    chk("low_cause", cause,      2);
    chk("low_errch", err_ch,     0);
    chk("low_info",  cause_info, 32'h00030000);

    // Exception beats range on the same cycle
    do_reset();
    ch_addr = {32'h00020000, 32'h0}; ch_ready = 2'b10; exception = 1'b1;
    exp_pc = pc;
    tick();
    ch_ready = 2'b00; exception = 1'b0;
    chk("exc_cause", cause,      1);
    chk("exc_info",  cause_info, exp_pc);

    // Reset while draining
    do_reset();
    st_valid = 1'b1; st_addr = EXIT_A; st_data = 32'd9;
    tick();
    st_valid = 1'b0;
    chk("drn_halt",  halt_req, 1);
    chk("drn_done0", done,     0);
    resetb = 1'b1;
    tick();
    resetb = 1'b0;
    check_idle("drn_rst");
    pc_run = 1'b0;
    tick();
    chk("drn_stall0", stall_cnt, 0);
    tick();
    chk("drn_stall1", stall_cnt, 1);
    tick();
    chk("drn_stall2", stall_cnt, 2);
    pc_run = 1'b1;
    st_valid = 1'b1; st_addr = EXIT_A; st_data = 32'd5;
    tick();
    st_valid = 1'b0;
    chk("drn_run_halt",  halt_req,   1);
    chk("drn_run_cause", cause,      3);
    chk("drn_run_info",  cause_info, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
